// File: rtl/qsys_oci_dct_pkg.sv
// Shared widths, limits and FSM state type for the OCI data-trace packer.
package qsys_oci_dct_pkg;

    localparam int SYM_W   = 2;
    localparam int NUM_SYM = 15;
    localparam int BUF_W   = SYM_W * NUM_SYM;
    localparam int CNT_W   = 4;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SYM);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        END,
        DONE
    } dct_state_t;

endpackage

// File: rtl/qsys_system_nios2_qsys_0_oci_dct_packer_if.sv
// Symbol-in and packed-word-out handshake bundle of the DCT packer.
interface qsys_system_nios2_qsys_0_oci_dct_packer_if;
    import qsys_oci_dct_pkg::*;

    logic             sym_valid;
    logic [SYM_W-1:0] sym_data;
    logic             sym_ready;
    logic             dct_valid;
    logic             dct_ready;
    logic [BUF_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;

    // The packer is the master of this bundle; the trace source/sink side is the slave.
    modport master (
        input  sym_valid, sym_data, dct_ready,
        output sym_ready, dct_valid, dct_buffer, dct_count
    );

    modport slave (
        output sym_valid, sym_data, dct_ready,
        input  sym_ready, dct_valid, dct_buffer, dct_count
    );

endinterface

// File: rtl/qsys_oci_dct_out_reg.sv
// Output holding register of the DCT packer: one packed word plus its valid/ready state.
module qsys_oci_dct_out_reg
    import qsys_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [BUF_W-1:0] i_buf,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [BUF_W-1:0] o_buf,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_free
);

    logic             r_valid;
    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;

    // Loads only happen when free, so the word never changes while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_buf   <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_buf   <= i_buf;
            r_cnt   <= i_cnt;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_buf   = r_buf;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/qsys_system_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace symbols into 15-symbol DCT words and sequences end of test.
// Optional QSYS_OCI_DCT_DROP_EN: never backpressure in RUN, count discarded symbols.
module qsys_system_nios2_qsys_0_oci_dct_packer
    import qsys_oci_dct_pkg::*;
(
    input  logic clk,
    input  logic reset,
    qsys_system_nios2_qsys_0_oci_dct_packer_if.master bus,
    input  logic flush,
    input  logic end_req,
    output logic test_ending,
    output logic test_has_ended
`ifdef QSYS_OCI_DCT_DROP_EN
    ,
    output logic [7:0] drop_count
`endif
);

    logic [BUF_W-1:0] r_acc;
    logic [CNT_W-1:0] r_acc_cnt;
    dct_state_t       r_state;
    logic             r_live;
    logic             r_test_ending;
    logic             r_test_has_ended;

    logic [BUF_W-1:0] w_acc_base;
    logic [BUF_W-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_free;
    logic             w_drain;
    logic             w_xfer;
    logic             w_room;
    logic             w_sym_ready;
    logic             w_take;
    logic             w_dct_valid;
    logic [BUF_W-1:0] w_dct_buffer;
    logic [CNT_W-1:0] w_dct_count;

    assign w_drain = (r_state == FLUSH) || (r_state == END);
    assign w_xfer  = w_free && ((r_acc_cnt == FULL_CNT) || ((r_acc_cnt != '0) && w_drain));
    assign w_room  = (r_acc_cnt != FULL_CNT) || w_xfer;

`ifdef QSYS_OCI_DCT_DROP_EN
    logic       w_drop;
    logic [7:0] r_drop_count;

    assign w_sym_ready = r_live && (r_state == RUN);
    assign w_take      = bus.sym_valid && w_sym_ready && w_room;
    assign w_drop      = bus.sym_valid && w_sym_ready && !w_room;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign w_sym_ready = r_live && (r_state == RUN) && w_room;
    assign w_take      = bus.sym_valid && w_sym_ready;
`endif

    // A transfer empties the accumulator first, so a same-cycle symbol restarts it at count 1.
    always_comb begin
        w_acc_base = w_xfer ? '0 : r_acc;
        w_cnt_base = w_xfer ? '0 : r_acc_cnt;
        w_acc_next = w_acc_base;
        w_cnt_next = w_cnt_base;
        if (w_take) begin
            w_acc_next = {w_acc_base[BUF_W-SYM_W-1:0], bus.sym_data};
            w_cnt_next = w_cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
        end else begin
            r_acc     <= w_acc_next;
            r_acc_cnt <= w_cnt_next;
        end
    end

    // r_live keeps sym_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= RUN;
            r_live           <= 1'b0;
            r_test_ending    <= 1'b0;
            r_test_has_ended <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                RUN: begin
                    if (end_req) begin
                        r_state       <= END;
                        r_test_ending <= 1'b1;
                    end else if (flush) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (end_req) begin
                        r_state       <= END;
                        r_test_ending <= 1'b1;
                    end else if (w_cnt_next == '0) begin
                        r_state <= RUN;
                    end
                end
                END: begin
                    if ((r_acc_cnt == '0) && !w_dct_valid) begin
                        r_state          <= DONE;
                        r_test_has_ended <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
            endcase
        end
    end

    qsys_oci_dct_out_reg u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_xfer),
        .i_buf   (r_acc),
        .i_cnt   (r_acc_cnt),
        .i_ready (bus.dct_ready),
        .o_valid (w_dct_valid),
        .o_buf   (w_dct_buffer),
        .o_cnt   (w_dct_count),
        .o_free  (w_free)
    );

    assign bus.sym_ready   = w_sym_ready;
    assign bus.dct_valid   = w_dct_valid;
    assign bus.dct_buffer  = w_dct_buffer;
    assign bus.dct_count   = w_dct_count;
    assign test_ending     = r_test_ending;
    assign test_has_ended  = r_test_has_ended;

endmodule

// File: doc/qsys_system_nios2_qsys_0_oci_dct_packer.md
# qsys_system_nios2_qsys_0_oci_dct_packer

Producer side of the OCI data-trace (DCT) channel of the Nios II debug core. It accepts a stream of 2-bit trace symbols and packs up to 15 of them into a 30-bit `dct_buffer` word with a 4-bit `dct_count`. It delivers each packed word over a valid/ready handshake to the trace sink. It also generates the `test_ending` / `test_has_ended` end-of-test indications that the sink consumes.

## Interface
Parameters:
- `SYM_W`, 2: bits per trace symbol.
- `NUM_SYM`, 15: symbols per word. `BUF_W` = `SYM_W*NUM_SYM` = 30.
- `CNT_W`, 4: width of `dct_count`.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1: the single clock.
  - `reset` in 1: asynchronous, active-high.
- Symbol input:
  - `sym_valid` in 1: trace symbol present.
  - `sym_data` in 2: trace symbol.
  - `sym_ready` out 1: symbol accepted when `sym_valid && sym_ready`.
- Control:
  - `flush` in 1: single-cycle pulse; emit the partial word.
  - `end_req` in 1: single-cycle pulse; final flush, then end of test.
- Word output:
  - `dct_valid` out 1: packed word present.
  - `dct_ready` in 1: sink accepts the word.
  - `dct_buffer` out 30: packed symbols.
  - `dct_count` out 4: number of valid symbols in `dct_buffer`, 1..15.
- End-of-test:
  - `test_ending` out 1: end sequence in progress or complete.
  - `test_has_ended` out 1: all trace drained; sticky.

## Operation
- Accumulator: 30-bit shift register `acc` plus count `acc_cnt` (0..15).
  - On accept: `acc <= {acc[27:0], sym_data}` and `acc_cnt++`.
  - The word is right-justified: the oldest symbol is at the highest occupied position, and unused upper bits are 0.
- Output holding register (`out_buf`, `out_cnt`, `dct_valid`).
  - It is free when `!dct_valid || dct_ready`.
- Transfer `acc` → output holding register when the register is free and either:
  - `acc_cnt == 15`, or
  - `acc_cnt > 0` and the state is FLUSH or END.
- A transfer and a symbol accept in the same cycle restart `acc` with that symbol, so `acc_cnt` becomes 1.
- `sym_ready` = state RUN && (`acc_cnt < 15` || transfer this cycle).
- A word with `dct_count == 0` is never emitted.
- State machine (registered):
  - **RUN**
    - `flush` → FLUSH.
    - `end_req` → END (`end_req` wins if both are asserted).
  - **FLUSH**
    - Go to RUN when `acc_cnt == 0` after the transfer.
    - `end_req` → END.
  - **END**
    - Go to DONE when `acc_cnt == 0` and `dct_valid == 0`.
  - **DONE**
    - Terminal until reset.
- A symbol accepted in the same cycle as `flush` or `end_req` is included in the flushed word.
- `flush` or `end_req` with `acc_cnt == 0` emits no word.
- Outputs:
  - `test_ending` = state ∈ {END, DONE}.
  - `test_has_ended` = state == DONE.
  - Both are registered.
- Reset values:
  - `acc`, `acc_cnt`, `dct_buffer`, `dct_count` = 0.
  - `dct_valid`, `sym_ready`, `test_ending`, `test_has_ended` = 0.
  - State = RUN.
  - `sym_ready` rises the first cycle after reset deasserts.

## Timing
- Latency: the word-completing symbol is sampled at edge N; `dct_valid` is high after edge N+1, provided the holding register is free.
- Sustained throughput: 1 symbol per cycle with `dct_ready` held at 1.
- `dct_buffer`/`dct_count` are stable while `dct_valid && !dct_ready`.
- Flush: with the holding register free, the partial word appears 2 edges after the `flush` pulse.
- `test_has_ended` rises 1 cycle after the last word handshake.
- Asserting `reset` mid-word or mid-handshake clears everything immediately. Pending data is discarded and nothing is emitted after release.

## Configuration
- `QSYS_OCI_DCT_DROP_EN` defined:
  - `sym_ready` is held at 1 in RUN.
  - Symbols that cannot be accepted are discarded.
  - Each discarded symbol increments an 8-bit saturating output port `drop_count`, which resets to 0.
- Undefined:
  - Backpressure via `sym_ready` as described above.
  - No `drop_count` port.

## Structure
- Package `qsys_oci_dct_pkg` contains:
  - `SYM_W`, `NUM_SYM`, `BUF_W`, `CNT_W`.
  - State enum `dct_state_t` {RUN, FLUSH, END, DONE}.
- One sub-module, `qsys_oci_dct_out_reg`: the output holding register and its valid/ready logic.

## Test plan
- Single full word: 15 symbols `i%4` (i = 0..14), `dct_ready` = 1 → one word, `dct_count` = 15, `dct_buffer[29:28]` = 0, `dct_buffer[1:0]` = 2, `dct_valid` high after the edge following the 15th accept.
- Backpressure: `dct_ready` = 0, offer 31 symbols → 30 accepted, `sym_ready` low after the 30th; then `dct_ready` = 1 → two words, each `dct_count` = 15, in order; the 31st symbol is then accepted.
- Partial flush: symbols 3, 2, 1 then `flush` → `dct_count` = 3, `dct_buffer` = 30'h39, state returns to RUN.
- End of test: 5 symbols, then `end_req`, with `dct_ready` = 1 → `test_ending` = 1 next cycle, word with `dct_count` = 5, `test_has_ended` = 1 one cycle after its handshake, `sym_ready` stays 0.
- Reset mid-operation: `acc_cnt` = 7 and `dct_valid` = 1 with `dct_ready` = 0, pulse `reset` → all outputs 0 immediately, no word after release.
- Drop mode (`QSYS_OCI_DCT_DROP_EN`): `dct_ready` = 0, 40 symbols → `drop_count` = 10; saturation check at 255.
